// File: rtl/riskproc_pkg.sv
// Shared definitions for the proc data-side responder: I/O register offsets,
// address decode classes and the saturating counter helper.
package riskproc_pkg;

  localparam logic [3:0] IO_LEDR    = 4'h0;
  localparam logic [3:0] IO_WCOUNT  = 4'h4;
  localparam logic [3:0] IO_STATUS  = 4'h8;
  localparam logic [3:0] IO_ERRADDR = 4'hC;

  typedef enum logic [1:0] {
    DEC_RAM      = 2'd0,
    DEC_IO       = 2'd1,
    DEC_MISALIGN = 2'd2,
    DEC_UNMAPPED = 2'd3
  } dec_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM, write-first. Writes are discarded while the
// reset is held so a bus write during reset never lands in the array.
module ram_sp #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  // Array contents are never reset; only the read register is.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      if (we_i) mem[addr_i] <= wdata_i;
      rdata_q <= we_i ? wdata_i : mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Data-side bus responder for proc: decodes ADDR into RAM / I/O / error
// classes, keeps LED, write-count and sticky error registers, returns DIN.
module mem_responder
  import riskproc_pkg::*;
#(
  parameter int          MEM_WORDS_LOG2 = 8,
  parameter logic [31:0] IO_BASE        = 32'h0001_0000
) (
  input  logic        CLOCK_50,
  input  logic        Resetn,
  input  logic [31:0] ADDR,
  input  logic [31:0] DOUT,
  input  logic        W,
  output logic [31:0] DIN,
  output logic [9:0]  LEDR,
  output logic [15:0] WCOUNT,
  output logic        ERR
);

  localparam int AW = MEM_WORDS_LOG2;

  dec_e        dec;
  logic [31:0] io_off;

  logic [9:0]  ledr_q, ledr_d;
  logic [15:0] wcount_q, wcount_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [31:0] io_rd_q, io_rd_d;
  logic        ram_sel_q, ram_sel_d;
  logic        ram_we;
  logic [31:0] ram_rdata;

  // Underflow of ADDR - IO_BASE wraps high, so one compare bounds both ends.
  always_comb begin
    io_off = ADDR - IO_BASE;
    if (ADDR[1:0] != 2'b00)           dec = DEC_MISALIGN;
    else if (ADDR[31:AW+2] == '0)     dec = DEC_RAM;
    else if (io_off < 32'd16)         dec = DEC_IO;
    else                              dec = DEC_UNMAPPED;
  end

  always_comb begin
    ledr_d     = ledr_q;
    wcount_d   = wcount_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    io_rd_d    = '0;
    ram_sel_d  = 1'b0;
    ram_we     = 1'b0;
    case (dec)
      DEC_RAM: begin
        ram_sel_d = 1'b1;
        if (W) begin
          ram_we   = 1'b1;
          wcount_d = sat_inc16(wcount_q);
        end
      end
      DEC_IO: begin
        if (W) wcount_d = sat_inc16(wcount_q);
        // Read data reflects the post-write register value (write-first).
        case (io_off[3:0])
          IO_LEDR: begin
            if (W) ledr_d = DOUT[9:0];
            io_rd_d = {22'b0, ledr_d};
          end
          IO_WCOUNT: begin
            if (W) wcount_d = '0;
            io_rd_d = {16'b0, wcount_d};
          end
          IO_STATUS: begin
            if (W) begin
              err_d      = 1'b0;
              err_addr_d = '0;
            end
            io_rd_d = {31'b0, err_d};
          end
          default: io_rd_d = err_addr_q;
        endcase
      end
      default: begin
        // Only the first failing address is kept until software clears it.
        if (!err_q) begin
          err_d      = 1'b1;
          err_addr_d = ADDR;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      ledr_q     <= '0;
      wcount_q   <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      io_rd_q    <= '0;
      ram_sel_q  <= 1'b0;
    end else begin
      ledr_q     <= ledr_d;
      wcount_q   <= wcount_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      io_rd_q    <= io_rd_d;
      ram_sel_q  <= ram_sel_d;
    end
  end

  ram_sp #(.AW(AW), .DW(32)) u_ram (
    .clk_i   (CLOCK_50),
    .rst_ni  (Resetn),
    .we_i    (ram_we),
    .addr_i  (ADDR[AW+1:2]),
    .wdata_i (DOUT),
    .rdata_o (ram_rdata)
  );

  assign DIN    = ram_sel_q ? ram_rdata : io_rd_q;
  assign LEDR   = ledr_q;
  assign WCOUNT = wcount_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reset, RAM/IO access, error capture,
// counter saturation and reset during a write burst.
module tb_mem_responder;

  localparam logic [31:0] IOB = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] dout = '0;
  logic        w = 1'b0;
  logic [31:0] din;
  logic [9:0]  ledr;
  logic [15:0] wcount;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_responder #(.MEM_WORDS_LOG2(8), .IO_BASE(IOB)) dut (
    .CLOCK_50 (clk),
    .Resetn   (rstn),
    .ADDR     (addr),
    .DOUT     (dout),
    .W        (w),
    .DIN      (din),
    .LEDR     (ledr),
    .WCOUNT   (wcount),
    .ERR      (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one bus cycle, clock it, and sample 1 time unit after the edge.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic wr);
    addr = a;
    dout = d;
    w    = wr;
    @(posedge clk);
    #1;
    w = 1'b0;
  endtask

  initial begin
    #1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_din", din, 32'h0);
    chk("rst_ledr", {22'b0, ledr}, 32'h0);
    chk("rst_wcount", {16'b0, wcount}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    rstn = 1'b1;

    step(IOB, 32'h0, 1'b0);
    chk("idle_read_ledr", din, 32'h0);
    chk("idle_err", {31'b0, err}, 32'h0);

    step(32'h10, 32'hDEAD_BEEF, 1'b1);
    chk("ram_wr_first", din, 32'hDEAD_BEEF);
    chk("ram_wr_count", {16'b0, wcount}, 32'd1);
    step(32'h10, 32'h0, 1'b0);
    chk("ram_rd", din, 32'hDEAD_BEEF);

    step(IOB, 32'h0000_03FF, 1'b1);
    chk("led_wr_ledr", {22'b0, ledr}, 32'h3FF);
    chk("led_wr_din", din, 32'h0000_03FF);
    chk("led_wr_count", {16'b0, wcount}, 32'd2);
    step(IOB, 32'hFFFF_FC01, 1'b1);
    chk("led_trunc_din", din, 32'h0000_0001);
    chk("led_trunc_ledr", {22'b0, ledr}, 32'h001);

    step(32'h13, 32'h0, 1'b0);
    chk("misalign_err", {31'b0, err}, 32'h1);
    chk("misalign_din", din, 32'h0);
    step(32'h0002_0000, 32'h1234, 1'b1);
    chk("unmapped_din", din, 32'h0);
    chk("unmapped_nocount", {16'b0, wcount}, 32'd3);
    chk("unmapped_ledr", {22'b0, ledr}, 32'h001);
    step(IOB + 32'hC, 32'h0, 1'b0);
    chk("erraddr_first", din, 32'h13);
    step(IOB + 32'h8, 32'h0, 1'b0);
    chk("status_rd", din, 32'h1);
    step(IOB + 32'h8, 32'h0, 1'b1);
    chk("status_clr_err", {31'b0, err}, 32'h0);
    chk("status_clr_din", din, 32'h0);
    chk("status_clr_count", {16'b0, wcount}, 32'd4);
    step(IOB + 32'hC, 32'h0, 1'b0);
    chk("erraddr_cleared", din, 32'h0);

    step(IOB + 32'h10, 32'h0, 1'b0);
    chk("io_past_end_err", {31'b0, err}, 32'h1);
    step(IOB + 32'hC, 32'hFFFF_FFFF, 1'b1);
    chk("erraddr_ro", din, IOB + 32'h10);
    chk("erraddr_wr_count", {16'b0, wcount}, 32'd5);
    step(IOB + 32'h8, 32'h0, 1'b1);
    chk("status_clr2", {31'b0, err}, 32'h0);

    step(32'h3FC, 32'h1234_5678, 1'b1);
    step(32'h3FC, 32'h0, 1'b0);
    chk("ram_last_word", din, 32'h1234_5678);
    chk("ram_last_count", {16'b0, wcount}, 32'd7);
    step(32'h400, 32'h0, 1'b0);
    chk("ram_end_err", {31'b0, err}, 32'h1);
    step(IOB + 32'hC, 32'h0, 1'b0);
    chk("ram_end_erraddr", din, 32'h400);
    step(IOB + 32'h8, 32'h0, 1'b1);

    for (int i = 0; i < 65540; i++) step((i % 256) * 4, i, 1'b1);
    chk("wcount_sat", {16'b0, wcount}, 32'h0000_FFFF);
    step(32'h40, 32'h0, 1'b1);
    chk("wcount_sat_hold", {16'b0, wcount}, 32'h0000_FFFF);
    step(IOB + 32'h4, 32'hABCD, 1'b1);
    chk("wcount_clr", {16'b0, wcount}, 32'h0);
    chk("wcount_clr_din", din, 32'h0);
    step(32'h44, 32'h0, 1'b1);
    step(IOB + 32'h4, 32'h0, 1'b0);
    chk("wcount_rd", din, 32'h1);

    step(32'h20, 32'hAAAA_0000, 1'b1);
    step(32'h24, 32'h0000_BBBB, 1'b1);
    addr = 32'h20;
    dout = 32'h55;
    w    = 1'b1;
    rstn = 1'b0;
    #1;
    chk("async_rst_din", din, 32'h0);
    chk("async_rst_count", {16'b0, wcount}, 32'h0);
    chk("async_rst_ledr", {22'b0, ledr}, 32'h0);
    @(posedge clk);
    #1;
    w    = 1'b0;
    rstn = 1'b1;
    step(32'h20, 32'h0, 1'b0);
    chk("rst_write_dropped", din, 32'hAAAA_0000);
    step(32'h24, 32'h0, 1'b0);
    chk("ram_kept", din, 32'h0000_BBBB);
    chk("post_rst_count", {16'b0, wcount}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-mapped data-side responder for `proc`. It decodes the processor's `ADDR`/`DOUT`/`W` bus, commits writes to a word-addressed synchronous RAM or an I/O register bank, and returns registered read data on `DIN`. It also keeps a saturating write counter and a sticky bus-error flag with the captured failing address. It sits beside `proc` in the top level and in benches, giving the processor's outgoing writes a real consumer.

## Interface
- `MEM_WORDS_LOG2`, 8: RAM depth is 2^MEM_WORDS_LOG2 32-bit words.
- `IO_BASE`, 32'h0001_0000: byte base address of the I/O register bank.
- `CLOCK_50`  in  1  single clock; all state updates on its rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `ADDR`  in  32  byte address from `proc`.
- `DOUT`  in  32  write data from `proc`.
- `W`  in  1  write strobe; 1 = write this cycle, 0 = read.
- `DIN`  out  32  registered read data to `proc`.
- `LEDR`  out  10  LED register contents.
- `WCOUNT`  out  16  count of committed writes.
- `ERR`  out  1  sticky bus-error flag.

## Operation
- Decode classes, evaluated every cycle:
  - Misaligned: `ADDR[1:0]` != 0.
  - RAM: aligned, and `ADDR` < 4·2^MEM_WORDS_LOG2.
  - IO: aligned, and `ADDR` in `IO_BASE`..`IO_BASE`+0xC.
  - Unmapped: anything else.
- RAM index is `ADDR[MEM_WORDS_LOG2+1:2]`.
- I/O registers, offsets from `IO_BASE`:
  - +0x0 `LEDR`: R/W, `DOUT[9:0]`; reads zero-extended.
  - +0x4 `WCOUNT`: R/W; any write clears it to 0, and that write is not counted.
  - +0x8 status: read = {31'b0, ERR}; any write clears `ERR` and `ERR_ADDR`.
  - +0xC `ERR_ADDR`: read-only; writes are ignored and count as committed.
- Committed write: `W`=1 to a RAM or IO class address.
  - `WCOUNT` increments by 1, saturating at 16'hFFFF.
  - Exception: a write to +0x4 clears `WCOUNT` instead of incrementing it.
- Misaligned or unmapped access (read or write):
  - No state change other than the error logic below.
  - `DIN` <= 0.
  - If `ERR`=0: `ERR` <= 1 and `ERR_ADDR` <= `ADDR`. If `ERR` was already 1, `ERR_ADDR` keeps the first failing address.
- Reads (`W`=0) have no side effects.

## Timing
- Reset (`Resetn`=0, asynchronous): `DIN`=0, `LEDR`=0, `WCOUNT`=0, `ERR`=0, `ERR_ADDR`=0. RAM contents are not reset.
- A write presented on an edge where `Resetn` is low is discarded.
- `ADDR`/`DOUT`/`W` are sampled on rising edge k; results are visible after edge k.
- Read latency is 1 cycle: `DIN` after edge k = contents at the `ADDR` sampled at edge k.
- Write-first behaviour: when `W`=1 at edge k on a readable address, `DIN` after edge k = the newly written value (for `LEDR`, zero-extended `DOUT[9:0]`).
- Write-to-counter/status registers: `DIN` after edge k shows the post-write value (0).
- Back-to-back writes every cycle are supported with no stalls; the block never back-pressures.
- A status clear and a new error cannot coincide, because the clear write is itself a valid access.

## Structure
- Shared package `riskproc_pkg` holds:
  - I/O offset constants: `IO_LEDR`=0x0, `IO_WCOUNT`=0x4, `IO_STATUS`=0x8, `IO_ERRADDR`=0xC.
  - Decode-class enum: `DEC_RAM`, `DEC_IO`, `DEC_MISALIGN`, `DEC_UNMAPPED`.
- Sub-module `ram_sp`: single-port synchronous RAM, write-first, parameterised by depth.
- The top level keeps the decode, I/O registers, counter and error logic.

## Test plan
- Reset, then hold idle → all outputs 0; `DIN` stays 0 while reading `IO_BASE`+0x0.
- Write 32'hDEAD_BEEF to 0x10, then read 0x10 on the next cycle → `DIN`=32'hDEAD_BEEF one cycle after the read; `WCOUNT`=1.
- Write 32'h3FF to `IO_BASE` → `LEDR`=10'h3FF after the edge; `DIN`=32'h0000_03FF on the same edge (write-first).
- Access 0x13 (misaligned), then 0x0002_0000 (unmapped):
  - `ERR`=1 after the first access.
  - Read `IO_BASE`+0xC → `DIN`=0x13, the first failing address is kept.
  - Write `IO_BASE`+0x8 → `ERR`=0 and `ERR_ADDR`=0.
- 65540 consecutive RAM writes → `WCOUNT` saturates at 16'hFFFF; a write to `IO_BASE`+0x4 → `WCOUNT`=0.
- Assert `Resetn` low mid-burst while writing 0x55 to 0x20 → outputs 0 immediately; after release, a read of 0x20 does not return 0x55 (unless 0x20 was written earlier).
